// File: rtl/avalon_st_arb_pkg.sv
// Shared types, limits and helpers for the packet-aware Avalon-ST arbiter.

package avalon_st_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int unsigned MAX_INPUTS = 16;
    localparam int unsigned MIN_INPUTS = 2;

    // Modulo-n increment of a round-robin pointer.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/avalon_st_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.

module avalon_st_arbiter_rr_grant #(
    parameter int unsigned N = 4,
    localparam int unsigned CH_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    logic [CH_W:0]   pos;
    logic [CH_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (CH_W+1)'(k);
            if (pos >= (CH_W+1)'(N)) begin
                pos = pos - (CH_W+1)'(N);
            end
            cand = pos[CH_W-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/avalon_st_arbiter.sv
// Packet-aware round-robin merge of N_INPUTS Avalon-ST sources into one tagged stream.
// Define AVALON_ST_ARBITER_CHECK_EN to compile in protocol assertions.

module avalon_st_arbiter
    import avalon_st_arb_pkg::*;
#(
    parameter int unsigned N_INPUTS   = 4,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned CH_W      = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS-1:0]            in_valid,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_sop,
    input  logic [N_INPUTS-1:0]            in_eop,
    output logic [N_INPUTS-1:0]            in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [CH_W-1:0]                out_channel,
    input  logic                           out_ready
);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       owner;
    logic [N_INPUTS-1:0]   rr_gnt;
    logic [CH_W-1:0]       rr_idx;
    logic                  rr_any;
    logic [N_INPUTS-1:0]   grant;
    logic [CH_W-1:0]       xfer_idx;
    logic                  xfer;
    logic                  adv;
    logic [DATA_WIDTH-1:0] data_arr [N_INPUTS];

    assign adv      = ~out_valid | out_ready;
    assign in_ready = {N_INPUTS{adv & rst_n}} & grant;

    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
            data_arr[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    avalon_st_arbiter_rr_grant #(
        .N (N_INPUTS)
    ) u_rr_grant (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_gnt),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock onto a source from its first beat until its eop.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (xfer && !in_eop[xfer_idx]) begin
                    state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (xfer && in_eop[owner]) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        xfer_idx = rr_idx;
        xfer     = 1'b0;
        case (state)
            ARB_IDLE: begin
                grant = rr_gnt;
                xfer  = adv & rr_any;
            end
            ARB_LOCKED: begin
                grant[owner] = 1'b1;
                xfer_idx     = owner;
                xfer         = adv & in_valid[owner];
            end
            default: ;
        endcase
    end

    // Pointer moves past a source only once its packet has ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            owner  <= '0;
        end else if (xfer) begin
            if (in_eop[xfer_idx]) begin
                rr_ptr <= CH_W'(rr_next(32'(xfer_idx), N_INPUTS));
            end else if (state == ARB_IDLE) begin
                owner <= xfer_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_channel <= '0;
        end else if (adv) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data    <= data_arr[xfer_idx];
                out_sop     <= in_sop[xfer_idx];
                out_eop     <= in_eop[xfer_idx];
                out_channel <= xfer_idx;
            end
        end
    end

`ifdef AVALON_ST_ARBITER_CHECK_EN
    initial begin
        if (N_INPUTS < MIN_INPUTS || N_INPUTS > MAX_INPUTS) begin
            $fatal(1, "avalon_st_arbiter: N_INPUTS=%0d out of range", N_INPUTS);
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant))
        else $error("avalon_st_arbiter: grant not one-hot-or-zero");

    a_idle_sop: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ARB_IDLE && xfer) |-> in_sop[xfer_idx])
        else $error("avalon_st_arbiter: packet start without sop");

    a_locked_sop: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ARB_LOCKED && xfer) |-> !in_sop[owner])
        else $error("avalon_st_arbiter: sop inside locked packet");

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sop)
                                       && $stable(out_eop) && $stable(out_channel)))
        else $error("avalon_st_arbiter: output changed under backpressure");

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_valid_hold
        a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (in_valid[g] && !in_ready[g]) |=> in_valid[g])
            else $error("avalon_st_arbiter: in_valid[%0d] dropped before handshake", g);
    end
`endif

endmodule

// File: tb/tb_avalon_st_arbiter.sv
// Directed vector table plus reset and random-traffic sequences for avalon_st_arbiter.

module tb_avalon_st_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_sop;
    logic [N-1:0]    in_eop;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic [1:0]      out_channel;
    logic            out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avalon_st_arbiter #(
        .N_INPUTS   (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_channel (out_channel),
        .out_ready   (out_ready)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  sop;
        logic [3:0]  eop;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_d;
        logic [1:0]  exp_ch;
        logic        exp_sop;
        logic        exp_eop;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] v, input logic [31:0] d, input logic [3:0] s,
                                input logic [3:0] e, input logic r, input logic [3:0] xr,
                                input logic xov, input logic [7:0] xd, input logic [1:0] xc,
                                input logic xs, input logic xe);
        vec_t t;
        t.valid = v; t.data = d; t.sop = s; t.eop = e; t.ordy = r;
        t.exp_rdy = xr; t.exp_ov = xov; t.exp_d = xd; t.exp_ch = xc;
        t.exp_sop = xs; t.exp_eop = xe;
        vecs.push_back(t);
    endfunction

    // Random-phase state
    bit    act [N];
    bit    pres[N];
    int    len [N];
    int    idx [N];
    int    seq [N];
    int    wait_cnt[N];
    beat_t exp_q[N][$];
    beat_t exp_b;
    bit    in_pkt;
    logic [1:0] pkt_ch;
    bit    gen_on;
    bit    busy;
    int    ch;

    initial begin
        // Single-beat packets from every source, served in channel order
        add(4'b1111, 32'h13121110, 4'b1111, 4'b1111, 1, 4'b0001, 1, 8'h10, 2'd0, 1, 1);
        add(4'b1110, 32'h13121110, 4'b1111, 4'b1111, 1, 4'b0010, 1, 8'h11, 2'd1, 1, 1);
        add(4'b1100, 32'h13121110, 4'b1111, 4'b1111, 1, 4'b0100, 1, 8'h12, 2'd2, 1, 1);
        add(4'b1000, 32'h13121110, 4'b1111, 4'b1111, 1, 4'b1000, 1, 8'h13, 2'd3, 1, 1);
        add(4'b0000, 32'h0,        4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 2'd0, 0, 0);
        // Source 1 three-beat packet holds the lock against source 2
        add(4'b0110, 32'h00DDAA00, 4'b0110, 4'b0100, 1, 4'b0010, 1, 8'hAA, 2'd1, 1, 0);
        add(4'b0110, 32'h00DDBB00, 4'b0100, 4'b0100, 1, 4'b0010, 1, 8'hBB, 2'd1, 0, 0);
        add(4'b0110, 32'h00DDCC00, 4'b0100, 4'b0110, 1, 4'b0010, 1, 8'hCC, 2'd1, 0, 1);
        add(4'b0100, 32'h00DD0000, 4'b0100, 4'b0100, 1, 4'b0100, 1, 8'hDD, 2'd2, 1, 1);
        // Source 0 gaps mid-packet; source 3 stays blocked
        add(4'b0001, 32'h00000050, 4'b0001, 4'b0000, 1, 4'b0001, 1, 8'h50, 2'd0, 1, 0);
        add(4'b1000, 32'h33000000, 4'b1000, 4'b1000, 1, 4'b0001, 0, 8'h00, 2'd0, 0, 0);
        add(4'b1000, 32'h33000000, 4'b1000, 4'b1000, 1, 4'b0001, 0, 8'h00, 2'd0, 0, 0);
        add(4'b1001, 32'h33000051, 4'b1000, 4'b1001, 1, 4'b0001, 1, 8'h51, 2'd0, 0, 1);
        add(4'b1000, 32'h33000000, 4'b1000, 4'b1000, 1, 4'b1000, 1, 8'h33, 2'd3, 1, 1);
        add(4'b0000, 32'h0,        4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 2'd0, 0, 0);
        // Backpressure for five cycles holds the output beat
        add(4'b0010, 32'h00006100, 4'b0010, 4'b0010, 1, 4'b0010, 1, 8'h61, 2'd1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            add(4'b0100, 32'h00620000, 4'b0100, 4'b0100, 0, 4'b0000, 1, 8'h61, 2'd1, 1, 1);
        end
        add(4'b0100, 32'h00620000, 4'b0100, 4'b0100, 1, 4'b0100, 1, 8'h62, 2'd2, 1, 1);
        add(4'b0000, 32'h0,        4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 2'd0, 0, 0);

        // Reset state, with every source requesting
        rst_n = 1'b0; in_valid = 4'b1111; in_data = '0; in_sop = 4'b1111; in_eop = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sopeop", 32'({out_sop, out_eop}), 32'h0);
        chk("rst_out_channel", 32'(out_channel), 32'h0);
        in_valid = '0; in_sop = '0; in_eop = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid = vecs[i].valid; in_data = vecs[i].data;
            in_sop = vecs[i].sop; in_eop = vecs[i].eop; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                chk($sformatf("v%0d_out_beat", i), 32'({out_channel, out_sop, out_eop, out_data}),
                    32'({vecs[i].exp_ch, vecs[i].exp_sop, vecs[i].exp_eop, vecs[i].exp_d}));
            end
        end

        // Reset during the 2nd beat of a 4-beat packet from source 2
        @(negedge clk);
        in_valid = 4'b0100; in_data = 32'h00A00000; in_sop = 4'b0100; in_eop = 4'b0000; out_ready = 1'b1;
        #1; chk("mr_b1_in_ready", 32'(in_ready), 32'h4);
        @(posedge clk); #1;
        chk("mr_b1_out", 32'({out_valid, out_channel, out_data}), 32'({1'b1, 2'd2, 8'hA0}));
        @(negedge clk);
        in_data = 32'h00A10000; in_sop = 4'b0000;
        #1; chk("mr_b2_in_ready", 32'(in_ready), 32'h4);
        #2; rst_n = 1'b0;
        #1;
        chk("mr_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mr_rst_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b0110; in_data = 32'h00B2B100; in_sop = 4'b0110; in_eop = 4'b0110;
        #1; chk("mr_after_in_ready", 32'(in_ready), 32'h2);
        @(posedge clk); #1;
        chk("mr_after_out", 32'({out_valid, out_channel, out_data}), 32'({1'b1, 2'd1, 8'hB1}));
        @(negedge clk);
        in_valid = '0; in_sop = '0; in_eop = '0;
        @(posedge clk); #1;
        chk("mr_drain_out_valid", 32'(out_valid), 32'h0);

        // Random traffic on all sources with random downstream ready
        for (int s = 0; s < N; s++) begin
            act[s] = 0; pres[s] = 0; len[s] = 1; idx[s] = 0; seq[s] = 0; wait_cnt[s] = 0;
        end
        in_pkt = 0; pkt_ch = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            gen_on = (cyc < 2000);
            @(negedge clk);
            for (int s = 0; s < N; s++) begin
                if (!pres[s]) begin
                    if (!act[s] && gen_on && $urandom_range(0, 2) == 0) begin
                        act[s] = 1; len[s] = $urandom_range(1, 4); idx[s] = 0;
                    end
                    if (act[s] && $urandom_range(0, 3) != 0) pres[s] = 1;
                end
                in_valid[s] = pres[s];
                in_data[s*DW +: DW] = 8'((s << 6) | (seq[s] & 63));
                in_sop[s] = (idx[s] == 0);
                in_eop[s] = (idx[s] == len[s] - 1);
            end
            out_ready = gen_on ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                ch = int'(out_channel);
                n_chk++;
                if (exp_q[ch].size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_out: unexpected beat ch %0d data %0h", ch, out_data);
                end else begin
                    exp_b = exp_q[ch].pop_front();
                    if ({out_data, out_sop, out_eop} !== exp_b || (in_pkt && out_channel != pkt_ch)) begin
                        n_fail++;
                        $display("FAIL rnd_out: got ch %0d d %0h s %0b e %0b, expected ch %0d d %0h s %0b e %0b",
                                 ch, out_data, out_sop, out_eop, in_pkt ? pkt_ch : out_channel,
                                 exp_b.d, exp_b.s, exp_b.e);
                    end
                end
                if (out_eop) in_pkt = 0;
                else begin in_pkt = 1; pkt_ch = out_channel; end
            end
            for (int s = 0; s < N; s++) begin
                if (in_valid[s] && in_ready[s]) begin
                    exp_q[s].push_back({in_data[s*DW +: DW], in_sop[s], in_eop[s]});
                    if (idx[s] == 0) begin
                        n_chk++;
                        if (wait_cnt[s] > N - 1) begin
                            n_fail++;
                            $display("FAIL rnd_fair: src %0d waited %0d packets, limit %0d", s, wait_cnt[s], N - 1);
                        end
                        wait_cnt[s] = 0;
                        for (int t = 0; t < N; t++) begin
                            if (t != s && pres[t] && idx[t] == 0) wait_cnt[t]++;
                        end
                    end
                    seq[s]++; idx[s]++; pres[s] = 0;
                    if (idx[s] == len[s]) act[s] = 0;
                end
            end
            busy = out_valid;
            for (int s = 0; s < N; s++) busy = busy | act[s] | (exp_q[s].size() != 0);
            if (!gen_on && !busy) break;
        end
        for (int s = 0; s < N; s++) begin
            chk($sformatf("rnd_drain_src%0d", s), 32'(exp_q[s].size()) | 32'(act[s]), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_st_arbiter.md
Name: avalon_st_arbiter

Overview:
- Packet-aware round-robin arbiter that merges N_INPUTS Avalon-ST source streams into one Avalon-ST stream.
- Sits in front of avalon_sampler, so several producers can share one sampler/output link.
- Grants are held for a whole packet, from startofpacket to endofpacket, so packets never interleave.
- The output is registered, with a channel tag.

Parameters:
- N_INPUTS, 4, number of requesting streams (2..16).
- DATA_WIDTH, 8, payload width per beat; must match the downstream avalon_st_if DATA_WIDTH.
- CH_W, $clog2(N_INPUTS), width of the channel tag (localparam, derived).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  N_INPUTS  per-source valid
- in_data  input  N_INPUTS*DATA_WIDTH  per-source data; source i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- in_sop  input  N_INPUTS  per-source startofpacket
- in_eop  input  N_INPUTS  per-source endofpacket
- in_ready  output  N_INPUTS  per-source ready, ready latency 0
- out_valid  output  1  registered valid
- out_data  output  DATA_WIDTH  registered data
- out_sop  output  1  registered startofpacket
- out_eop  output  1  registered endofpacket
- out_channel  output  CH_W  index of the source that produced the beat
- out_ready  input  1  downstream ready, ready latency 0

Behaviour:
- Clock and reset (fixed):
  - Single clock, clk.
  - Asynchronous active-low reset, rst_n.
  - On reset: out_valid=0, out_data=0, out_sop=0, out_eop=0, out_channel=0, state=IDLE, rr_ptr=0, owner=0.
  - in_ready is combinational and is 0 while in reset.
- Output stage:
  - adv = ~out_valid | out_ready.
  - A beat transfers from source i when in_valid[i] & in_ready[i].
  - On transfer, the output register loads data/sop/eop/channel and out_valid=1.
  - If adv=1 and no transfer occurs, out_valid=0.
  - If adv=0, the register holds.
  - Latency is 1 cycle input-to-output. Throughput is 1 beat/cycle under continuous out_ready.
- Grant:
  - in_ready[i] = adv & grant[i].
  - grant is one-hot or zero.
- IDLE:
  - grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo N_INPUTS.
  - On transfer with eop=0: go to LOCKED, owner=i.
  - On transfer with eop=1 (single-beat packet): stay IDLE, rr_ptr=(i+1) mod N_INPUTS.
  - With no valid input: grant=0 and rr_ptr holds.
- LOCKED:
  - grant = onehot(owner) only; other sources see in_ready=0 even when valid.
  - On an owner transfer with eop=1: go to IDLE, rr_ptr=(owner+1) mod N_INPUTS.
  - Owner valid deasserted mid-packet: stay LOCKED and emit bubbles; no timeout.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and the state holds.
- Simultaneous requests: exactly one grant, per the round-robin order above. No source starves; every source is served within N_INPUTS packets.
- sop handling:
  - A beat without sop arriving in IDLE is treated as a packet start.
  - A sop arriving in LOCKED is passed through unchanged.
- Reset mid-packet: the packet is abandoned, the output clears, and arbitration restarts at source 0.

Optional Feature:
- Macro: AVALON_ST_ARBITER_CHECK_EN.
- With the macro defined, SVA concurrent assertions are compiled in; each fires $error:
  - grant is one-hot-or-zero.
  - IDLE transfer without sop.
  - LOCKED transfer with sop.
  - out_data, out_sop, out_eop, out_channel and out_valid are stable while out_valid & ~out_ready.
  - in_valid[i] dropped before a handshake.
- Also with the macro defined, an initial check issues $fatal if N_INPUTS<2 or N_INPUTS>16.
- Without the macro: no checks and identical RTL behaviour.

Decomposition:
- Package avalon_st_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
  - Constants MAX_INPUTS=16 and MIN_INPUTS=2.
  - Function rr_next(ptr, n) for the modulo increment.
- Sub-module _rr_grant (combinational):
  - Inputs: req[N], ptr[CH_W].
  - Outputs: grant[N] one-hot, idx[CH_W], any.
  - It is reused later by other schedulers.

Test Plan:
- N_INPUTS=4; sources 0..3 each hold one single-beat packet (sop=eop=1, data=8'h10+i), out_ready=1 -> outputs in channel order 0,1,2,3 on consecutive cycles, first out_valid 1 cycle after the first transfer.
- Source 1 sends a 3-beat packet (AA, BB, CC) while source 2 is valid throughout -> out_channel=1 for AA, BB, CC contiguously, then source 2; in_ready[2]=0 during the lock.
- Source 0 mid-packet drops in_valid for 2 cycles while source 3 is valid -> 2 bubble cycles (out_valid=0), source 3 is not granted, and the lock is kept until source 0's eop.
- out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_channel are stable, all in_ready=0, and no beat is lost or duplicated after release.
- Assert rst_n=0 during the 2nd beat of a 4-beat packet from source 2 -> out_valid=0 immediately; after release, with sources 1 and 2 valid, source 1 wins (rr_ptr=0).
- Continuous random traffic on all 4 sources, random out_ready -> the scoreboard matches per-channel packet order, and no source waits more than 4 packets.
